// File: rtl/tb_chk_pkg.sv
// Shared types and MISR arithmetic for the response checker and its reference model.
`timescale 1ns/1ps
package tb_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'hFFFF;

  // One MISR step on the low sig_w bits; data must already be zero-extended.
  function automatic logic [63:0] misr_step(input logic [63:0] sig,
                                            input logic [63:0] data,
                                            input logic [63:0] poly,
                                            input int          sig_w);
    logic [63:0] mask;
    logic [63:0] fb;
    mask = (64'd1 << sig_w) - 64'd1;
    fb   = sig[sig_w-1] ? poly : 64'd0;
    return (((sig << 1) ^ fb ^ data) & mask);
  endfunction

endpackage

// File: rtl/tb_response_checker_if.sv
// Valid/ready response beat carrying the observed and expected values of one vector.
`timescale 1ns/1ps
interface tb_response_checker_if #(
  parameter int RESP_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [RESP_W-1:0] in_resp;
  logic [RESP_W-1:0] in_exp;

  modport master (output in_valid, output in_resp, output in_exp, input in_ready);
  modport slave  (input in_valid, input in_resp, input in_exp, output in_ready);
endinterface

// File: rtl/misr_reg.sv
// Multiple-input signature register: clears to SEED, compacts din on each enabled cycle.
`timescale 1ns/1ps
module misr_reg
  import tb_chk_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter int               DIN_W = 3,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = {SIG_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIN_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_next;

  assign w_next = SIG_W'(misr_step(64'(r_sig), 64'(din), 64'(POLY), SIG_W));

  // Clear has priority over compaction so a restart always begins from SEED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= SEED;
    end else if (clr) begin
      r_sig <= SEED;
    end else if (en) begin
      r_sig <= w_next;
    end else begin
      r_sig <= r_sig;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/tb_response_checker.sv
// Response checker: compares beats, counts mismatches, compacts into a MISR, issues a verdict.
// Optional first-mismatch capture ports are enabled by defining TB_RESP_CHK_FIRST_ERR_EN.
`timescale 1ns/1ps
module tb_response_checker
  import tb_chk_pkg::*;
#(
  parameter int               RESP_W     = 3,
  parameter int               NUM_VEC    = 64,
  parameter int               SIG_W      = 16,
  parameter logic [SIG_W-1:0] POLY       = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED       = {SIG_W{1'b1}},
  parameter logic [SIG_W-1:0] GOLDEN_SIG = {SIG_W{1'b0}},
  parameter int               CNT_W      = $clog2(NUM_VEC + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  tb_response_checker_if.slave     bus,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [CNT_W-1:0]         vec_cnt,
`ifdef TB_RESP_CHK_FIRST_ERR_EN
  output logic [CNT_W-1:0]         first_err_idx,
  output logic [RESP_W-1:0]        first_err_resp,
  output logic [RESP_W-1:0]        first_err_exp,
`endif
  output logic [SIG_W-1:0]         signature
);

  chk_state_t       r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_vec_cnt;

  logic             w_accept;
  logic             w_start_run;
  logic             w_mismatch;
  logic             w_last;
  logic [CNT_W:0]   w_vec_wide;
  logic [CNT_W-1:0] w_err_next;
  logic [SIG_W-1:0] w_sig;
  logic [SIG_W-1:0] w_sig_next;

  assign bus.in_ready = (r_state == RUN);
  assign w_accept     = bus.in_valid && (r_state == RUN);
  assign w_start_run  = start && (r_state != RUN);
  assign w_mismatch   = (bus.in_resp != bus.in_exp);
  // One extra bit so the terminal count is reachable even with a deliberately narrow CNT_W.
  assign w_vec_wide   = {1'b0, r_vec_cnt} + (CNT_W+1)'(1);
  assign w_last       = (w_vec_wide == (CNT_W+1)'(NUM_VEC));
  assign w_sig_next   = SIG_W'(misr_step(64'(w_sig), 64'(bus.in_resp), 64'(POLY), SIG_W));

  // Saturating error count for the current beat.
  always_comb begin
    w_err_next = r_err_cnt;
    if (w_mismatch && (r_err_cnt != {CNT_W{1'b1}})) begin
      w_err_next = r_err_cnt + CNT_W'(1);
    end else begin
      w_err_next = r_err_cnt;
    end
  end

  misr_reg #(
    .SIG_W (SIG_W),
    .DIN_W (RESP_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_start_run),
    .en    (w_accept),
    .din   (bus.in_resp),
    .sig   (w_sig)
  );

  // Run-control FSM with counters and the verdict registered on the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err_cnt <= {CNT_W{1'b0}};
      r_vec_cnt <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err_cnt <= {CNT_W{1'b0}};
            r_vec_cnt <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          if (w_accept) begin
            r_vec_cnt <= w_vec_wide[CNT_W-1:0];
            r_err_cnt <= w_err_next;
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == {CNT_W{1'b0}}) && (w_sig_next == GOLDEN_SIG);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TB_RESP_CHK_FIRST_ERR_EN
  logic [CNT_W-1:0]  r_first_idx;
  logic [RESP_W-1:0] r_first_resp;
  logic [RESP_W-1:0] r_first_exp;

  // A zero error count before this beat means this mismatch is the first of the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_idx  <= {CNT_W{1'b0}};
      r_first_resp <= {RESP_W{1'b0}};
      r_first_exp  <= {RESP_W{1'b0}};
    end else if (w_start_run) begin
      r_first_idx  <= {CNT_W{1'b0}};
      r_first_resp <= {RESP_W{1'b0}};
      r_first_exp  <= {RESP_W{1'b0}};
    end else if (w_accept && w_mismatch && (r_err_cnt == {CNT_W{1'b0}})) begin
      r_first_idx  <= r_vec_cnt;
      r_first_resp <= bus.in_resp;
      r_first_exp  <= bus.in_exp;
    end
  end

  assign first_err_idx  = r_first_idx;
  assign first_err_resp = r_first_resp;
  assign first_err_exp  = r_first_exp;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_err_cnt;
  assign vec_cnt   = r_vec_cnt;
  assign signature = w_sig;

endmodule

// File: tb/tb_tb_response_checker.sv
// Self-checking bench: a cycle model for the 64-vector checker plus directed literal checks
// on a 2-vector instance (signature math, pass) and a narrow-counter instance (saturation).
`timescale 1ns/1ps
module tb_tb_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_m, start_s, start_t;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  tb_response_checker_if #(.RESP_W(3)) ifm();
  tb_response_checker_if #(.RESP_W(3)) ifs();
  tb_response_checker_if #(.RESP_W(3)) ift();

  logic        busy_m, done_m, pass_m, busy_s, done_s, pass_s, busy_t, done_t, pass_t;
  logic [6:0]  err_m, vec_m;
  logic [1:0]  err_s, vec_s, err_t, vec_t;
  logic [15:0] sig_m, sig_s, sig_t;
`ifdef TB_RESP_CHK_FIRST_ERR_EN
  logic [6:0]  fidx_m;
  logic [1:0]  fidx_s, fidx_t;
  logic [2:0]  fresp_m, fexp_m, fresp_s, fexp_s, fresp_t, fexp_t;
`endif

  tb_response_checker #(.NUM_VEC(64)) u_m (
    .clk(clk), .rst_n(rst_n), .start(start_m), .bus(ifm),
    .busy(busy_m), .done(done_m), .pass(pass_m), .err_cnt(err_m), .vec_cnt(vec_m),
`ifdef TB_RESP_CHK_FIRST_ERR_EN
    .first_err_idx(fidx_m), .first_err_resp(fresp_m), .first_err_exp(fexp_m),
`endif
    .signature(sig_m));

  tb_response_checker #(.NUM_VEC(2), .GOLDEN_SIG(16'hCF9F)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .bus(ifs),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_s), .vec_cnt(vec_s),
`ifdef TB_RESP_CHK_FIRST_ERR_EN
    .first_err_idx(fidx_s), .first_err_resp(fresp_s), .first_err_exp(fexp_s),
`endif
    .signature(sig_s));

  tb_response_checker #(.NUM_VEC(4), .CNT_W(2)) u_t (
    .clk(clk), .rst_n(rst_n), .start(start_t), .bus(ift),
    .busy(busy_t), .done(done_t), .pass(pass_t), .err_cnt(err_t), .vec_cnt(vec_t),
`ifdef TB_RESP_CHK_FIRST_ERR_EN
    .first_err_idx(fidx_t), .first_err_resp(fresp_t), .first_err_exp(fexp_t),
`endif
    .signature(sig_t));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signature as polynomial multiply-by-x modulo (x^16 + POLY), then add the data word.
  function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic [2:0] d);
    logic [16:0] v;
    v = {s, 1'b0};
    if (v[16]) v = v ^ {1'b1, 16'h1021};
    return v[15:0] ^ {13'd0, d};
  endfunction

  function automatic int sat_add(input int e, input bit mis, input int max);
    return (mis && e < max) ? e + 1 : e;
  endfunction

  // Reference model for the 64-vector instance: phase 0 idle, 1 running, 2 finished.
  int          m_phase, m_vec, m_err, m_fidx, m_fresp, m_fexp;
  logic [15:0] m_sig;
  logic        m_pass;
  bit          m_mis;
  assign m_mis = (ifm.in_resp != ifm.in_exp);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_vec <= 0; m_err <= 0; m_sig <= 16'hFFFF; m_pass <= 1'b0;
      m_fidx <= 0; m_fresp <= 0; m_fexp <= 0;
    end else if (m_phase != 1) begin
      if (start_m) begin
        m_phase <= 1; m_vec <= 0; m_err <= 0; m_sig <= 16'hFFFF; m_pass <= 1'b0;
        m_fidx <= 0; m_fresp <= 0; m_fexp <= 0;
      end
    end else if (ifm.in_valid) begin
      m_vec <= m_vec + 1;
      m_err <= sat_add(m_err, m_mis, 127);
      m_sig <= ref_misr(m_sig, ifm.in_resp);
      if (m_mis && m_err == 0) begin
        m_fidx <= m_vec; m_fresp <= int'(ifm.in_resp); m_fexp <= int'(ifm.in_exp);
      end
      if (m_vec + 1 == 64) begin
        m_phase <= 2;
        m_pass  <= (sat_add(m_err, m_mis, 127) == 0) && (ref_misr(m_sig, ifm.in_resp) == 16'h0000);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready", 32'(ifm.in_ready), 32'(m_phase == 1));
      chk("m_busy", 32'(busy_m), 32'(m_phase == 1));
      chk("m_done", 32'(done_m), 32'(m_phase == 2));
      if (m_phase == 2) chk("m_pass", 32'(pass_m), 32'(m_pass));
      chk("m_err_cnt", 32'(err_m), 32'(m_err));
      chk("m_vec_cnt", 32'(vec_m), 32'(m_vec));
      chk("m_signature", 32'(sig_m), 32'(m_sig));
`ifdef TB_RESP_CHK_FIRST_ERR_EN
      chk("m_first_idx", 32'(fidx_m), 32'(m_fidx));
      chk("m_first_resp", 32'(fresp_m), 32'(m_fresp));
      chk("m_first_exp", 32'(fexp_m), 32'(m_fexp));
`endif
    end
  end

  task automatic beat(input int which, input logic [2:0] r, input logic [2:0] e);
    case (which)
      0: begin ifm.in_valid = 1'b1; ifm.in_resp = r; ifm.in_exp = e; end
      1: begin ifs.in_valid = 1'b1; ifs.in_resp = r; ifs.in_exp = e; end
      default: begin ift.in_valid = 1'b1; ift.in_resp = r; ift.in_exp = e; end
    endcase
    @(posedge clk); #1;
    ifm.in_valid = 1'b0; ifs.in_valid = 1'b0; ift.in_valid = 1'b0;
  endtask

  task automatic pulse_start(input int which);
    case (which)
      0: start_m = 1'b1;
      1: start_s = 1'b1;
      default: start_t = 1'b1;
    endcase
    @(posedge clk); #1;
    start_m = 1'b0; start_s = 1'b0; start_t = 1'b0;
  endtask

  logic [15:0] sig_gap;
  logic [2:0]  d;

  initial begin
    rst_n = 1'b0; start_m = 1'b0; start_s = 1'b0; start_t = 1'b0;
    ifm.in_valid = 1'b0; ifm.in_resp = 3'd0; ifm.in_exp = 3'd0;
    ifs.in_valid = 1'b0; ifs.in_resp = 3'd0; ifs.in_exp = 3'd0;
    ift.in_valid = 1'b0; ift.in_resp = 3'd0; ift.in_exp = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sig", 32'(sig_m), 32'h0000FFFF);
    chk("rst_ready", 32'(ifm.in_ready), 32'd0);
    chk("rst_done", 32'(done_s), 32'd0);
    chk_en = 1'b1;

    // Beats offered while idle must be dropped.
    ifm.in_valid = 1'b1; ifm.in_resp = 3'd7; ifm.in_exp = 3'd0;
    repeat (3) @(posedge clk);
    #1 ifm.in_valid = 1'b0;
    @(negedge clk);
    chk("idle_drop_vec", 32'(vec_m), 32'd0);
    chk("idle_drop_err", 32'(err_m), 32'd0);

    // Gapped run.
    pulse_start(0);
    for (int i = 0; i < 64; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      d = 3'((i * 3 + 1) % 8);
      beat(0, d, d);
    end
    @(negedge clk);
    chk("gap_done", 32'(done_m), 32'd1);
    sig_gap = m_sig;

    // Restart from DONE, same data without gaps.
    pulse_start(0);
    @(negedge clk);
    chk("restart_vec", 32'(vec_m), 32'd0);
    chk("restart_busy", 32'(busy_m), 32'd1);
    for (int i = 0; i < 64; i++) begin
      d = 3'((i * 3 + 1) % 8);
      beat(0, d, d);
    end
    @(negedge clk);
    chk("nogap_sig", 32'(sig_m), 32'(sig_gap));
    chk("nogap_vec", 32'(vec_m), 32'd64);

    // Two mismatches, plus a start pulse in RUN that must be ignored.
    pulse_start(0);
    for (int i = 0; i < 64; i++) begin
      d = 3'(i % 8);
      if (i == 20) start_m = 1'b1;
      if (i == 5) beat(0, 3'd6, 3'd7);
      else if (i == 40) beat(0, 3'd1, 3'd2);
      else beat(0, d, d);
      start_m = 1'b0;
    end
    @(negedge clk);
    chk("mis_err", 32'(err_m), 32'd2);
    chk("mis_pass", 32'(pass_m), 32'd0);
    chk("mis_done", 32'(done_m), 32'd1);
`ifdef TB_RESP_CHK_FIRST_ERR_EN
    chk("mis_fidx", 32'(fidx_m), 32'd5);
    chk("mis_fresp", 32'(fresp_m), 32'd6);
    chk("mis_fexp", 32'(fexp_m), 32'd7);
`endif

    // Abort at beat 30.
    pulse_start(0);
    for (int i = 0; i < 30; i++) beat(0, 3'd2, 3'd3);
    rst_n = 1'b0;
    #2;
    chk("abort_busy", 32'(busy_m), 32'd0);
    chk("abort_vec", 32'(vec_m), 32'd0);
    chk("abort_err", 32'(err_m), 32'd0);
    chk("abort_sig", 32'(sig_m), 32'h0000FFFF);
    chk("abort_ready", 32'(ifm.in_ready), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    pulse_start(0);
    for (int i = 0; i < 64; i++) beat(0, 3'd5, 3'd5);
    @(negedge clk);
    chk("post_abort_done", 32'(done_m), 32'd1);

    // Signature math on the 2-vector instance.
    pulse_start(1);
    beat(1, 3'd0, 3'd0);
    @(negedge clk);
    chk("s_sig1", 32'(sig_s), 32'h0000EFDF);
    chk("s_done_early", 32'(done_s), 32'd0);
    beat(1, 3'd0, 3'd0);
    @(negedge clk);
    chk("s_sig2", 32'(sig_s), 32'h0000CF9F);
    chk("s_done", 32'(done_s), 32'd1);
    chk("s_pass", 32'(pass_s), 32'd1);
    pulse_start(1);
    @(negedge clk);
    chk("s_clr_sig", 32'(sig_s), 32'h0000FFFF);
    chk("s_clr_pass", 32'(pass_s), 32'd0);
    chk("s_clr_vec", 32'(vec_s), 32'd0);
    beat(1, 3'd0, 3'd0);
    beat(1, 3'd1, 3'd1);
    @(negedge clk);
    chk("s_sig3", 32'(sig_s), 32'h0000CF9E);
    chk("s_pass3", 32'(pass_s), 32'd0);
    chk("s_err3", 32'(err_s), 32'd0);
    chk("s_done3", 32'(done_s), 32'd1);

    // Saturation on the narrow-counter instance.
    pulse_start(2);
    for (int i = 0; i < 3; i++) beat(2, 3'd0, 3'd1);
    @(negedge clk);
    chk("t_err3", 32'(err_t), 32'd3);
    chk("t_done_early", 32'(done_t), 32'd0);
    beat(2, 3'd0, 3'd1);
    @(negedge clk);
    chk("t_err_sat", 32'(err_t), 32'd3);
    chk("t_done", 32'(done_t), 32'd1);
    chk("t_pass", 32'(pass_t), 32'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tb_response_checker.md
Name: tb_response_checker

Overview:
- Response-side counterpart of our exhaustive stimulus benches. It accepts one DUT response per applied vector over a valid/ready handshake and compares it against the expected value supplied on the same beat.
- It counts mismatches and compacts every response into a MISR signature.
- After NUM_VEC beats it issues a registered pass/fail verdict.
- It sits between the stimulus sequencer and the bench/scoreboard top, and can also be synthesised for on-FPGA self-test.

Parameters:
- RESP_W, 3, width of the DUT response and expected value.
- NUM_VEC, 64, number of vectors per run (for example 2^(1+1+2+2) for a 6-input-bit DUT).
- SIG_W, 16, MISR width; must be >= RESP_W.
- POLY, 16'h1021, MISR feedback polynomial (low SIG_W bits).
- SEED, all ones, MISR reset/start value.
- GOLDEN_SIG, 0, expected final signature.
- CNT_W, $clog2(NUM_VEC+1), width of the vector and error counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- in_valid  in  1  response beat valid.
- in_ready  out  1  checker can accept a beat.
- in_resp  in  RESP_W  observed DUT response.
- in_exp  in  RESP_W  expected response for the same vector.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.
- pass  out  1  verdict; valid only while done=1.
- err_cnt  out  CNT_W  mismatching beats, saturating.
- vec_cnt  out  CNT_W  beats accepted this run.
- signature  out  SIG_W  current MISR value.

Behaviour:
- Reset (async assert, sync release) sets: state=IDLE; in_ready, busy, done, pass = 0; err_cnt, vec_cnt = 0; signature = SEED.
- FSM is IDLE -> RUN -> DONE.
  - IDLE: in_ready=0. start moves to RUN and clears the counters, signature (to SEED) and pass.
  - RUN: in_ready=1 combinationally from state. start is ignored. A beat is accepted when in_valid && in_ready.
  - DONE: in_ready=0. Outputs hold. start behaves as in IDLE and begins a new run.
- On each accepted beat, all updates are visible on the next clock edge:
  - vec_cnt increments by 1.
  - err_cnt increments by 1 if in_resp != in_exp, and saturates at all-ones.
  - signature_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended in_resp.
- The beat that makes vec_cnt == NUM_VEC moves the FSM to DONE in the same edge.
- pass is registered at that same edge as (err_cnt_next == 0) && (signature_next == GOLDEN_SIG). done and pass therefore rise together, one cycle after the final handshake.
- in_valid with in_ready=0 (IDLE/DONE) is dropped with no state change. The source must hold the beat until the next run starts.
- Gaps in in_valid during RUN are allowed and do not affect the result.
- rst_n asserted mid-run aborts immediately to the reset values. No partial verdict is produced.
- Comparison is 2-state only. X/Z handling is the bench's responsibility.

Optional Feature:
- Macro: TB_RESP_CHK_FIRST_ERR_EN.
- When defined, the block adds outputs first_err_idx (CNT_W), first_err_resp (RESP_W) and first_err_exp (RESP_W). These capture vec_cnt, in_resp and in_exp of the first mismatching beat in a run and hold until the next start or reset. They reset to 0.
- When not defined, these ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Package tb_chk_pkg contains:
  - chk_state_t enum (IDLE, RUN, DONE);
  - default POLY/SEED constants;
  - a function misr_step(sig, data, poly) shared with the bench's reference model.
- One sub-module, misr_reg. It is parameterised by SIG_W/POLY/SEED and has ports clk, rst_n, clr, en, din, sig.
- The top keeps the FSM, counters and verdict logic.

Test Plan:
- Reset: assert rst_n=0 mid-simulation -> busy=0, done=0, pass=0, err_cnt=0, vec_cnt=0, signature=16'hFFFF, in_ready=0.
- Signature math: NUM_VEC=2, GOLDEN_SIG=16'hCF9F, two beats in_resp=0/in_exp=0 -> signature 16'hEFDF after beat 1 and 16'hCF9F after beat 2; done=1 and pass=1 one cycle after the last handshake.
- Mismatch: NUM_VEC=64, beat 5 in_resp=3'd6 vs in_exp=3'd7 and beat 40 mismatched, all others equal -> err_cnt=2, pass=0. With the _EN macro: first_err_idx=5, first_err_resp=6, first_err_exp=7.
- Handshake gaps: random in_valid deasserts during RUN, plus in_valid pulses in IDLE -> IDLE beats are ignored, and vec_cnt/signature match the gap-free run.
- Restart/abort: start pulse in RUN ignored; rst_n low at beat 30 -> reset values; start from DONE -> counters cleared, new run completes with a correct verdict.
- Saturation: NUM_VEC=4 with err counter forced narrow (CNT_W=2, all beats mismatched) -> err_cnt holds 3 and does not wrap; pass=0.
